// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, datapath width.
`timescale 1ns/1ps
package lsu_pkg;
   localparam int WORD_W = 32;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_CAP  = 3'd2,
      ST_WR   = 3'd3,
      ST_RSP  = 3'd4
   } lsu_state_e;
endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: extract/extend for loads, read-modify-write merge for stores.
`timescale 1ns/1ps
module lsu_lane
   import lsu_pkg::*;
(
   input  logic [1:0]        size,
   input  logic [1:0]        off,
   input  logic              sgn,
   input  logic [WORD_W-1:0] rdata,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] load_data,
   output logic [WORD_W-1:0] merge_data
);
   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Select the addressed byte and half from the fetched word.
   always_comb begin
      case (off)
         2'd0:    byte_s = rdata[7:0];
         2'd1:    byte_s = rdata[15:8];
         2'd2:    byte_s = rdata[23:16];
         default: byte_s = rdata[31:24];
      endcase
      if (off[1]) begin
         half_s = rdata[31:16];
      end else begin
         half_s = rdata[15:0];
      end
   end

   // Right-align and extend the selected lanes.
   always_comb begin
      case (size)
         SZ_BYTE: load_data = {{24{sgn & byte_s[7]}}, byte_s};
         SZ_HALF: load_data = {{16{sgn & half_s[15]}}, half_s};
         default: load_data = rdata;
      endcase
   end

   // Replace only the addressed lanes; the rest keep the fetched value.
   always_comb begin
      merge_data = rdata;
      case (size)
         SZ_BYTE: begin
            case (off)
               2'd0:    merge_data[7:0]   = wdata[7:0];
               2'd1:    merge_data[15:8]  = wdata[7:0];
               2'd2:    merge_data[23:16] = wdata[7:0];
               default: merge_data[31:24] = wdata[7:0];
            endcase
         end
         SZ_HALF: begin
            if (off[1]) begin
               merge_data[31:16] = wdata[15:0];
            end else begin
               merge_data[15:0]  = wdata[15:0];
            end
         end
         default: merge_data = wdata;
      endcase
   end
endmodule

// File: rtl/load_store_unit.sv
// Word-port load/store unit with sub-word extract and RMW merge.
// Optional: define LSU_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors.
`timescale 1ns/1ps
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_AW = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [MEM_AW-1:0] mem_addr,
   input  logic [31:0]       mem_rdata,
   output logic [MEM_AW-1:0] mem_waddr,
   output logic [31:0]       mem_wdata,
   output logic              mem_we
);
`ifdef LSU_MISALIGN_TRAP_EN
   localparam logic TRAP_EN = 1'b1;
`else
   localparam logic TRAP_EN = 1'b0;
`endif

   lsu_state_e        state_q, state_d;
   logic              req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d, mem_we_q, mem_we_d;
   logic [31:0]       rsp_rdata_q, rsp_rdata_d, mem_wdata_q, mem_wdata_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [MEM_AW-1:0] mem_addr_q, mem_addr_d, mem_waddr_q, mem_waddr_d;
   logic [MEM_AW-1:0] widx_q, widx_d;
   logic              we_q, we_d, sgn_q, sgn_d;
   logic [1:0]        size_q, size_d, off_q, off_d;
   logic [1:0]        sz_n_s, off_n_s;
   logic              mis_s;
   logic [31:0]       load_data_s, merge_data_s;
   logic              addr_unused;

   assign addr_unused = ^req_addr[31:MEM_AW+2];

   lsu_lane u_lane (
      .size       (size_q),
      .off        (off_q),
      .sgn        (sgn_q),
      .rdata      (mem_rdata),
      .wdata      (wdata_q),
      .load_data  (load_data_s),
      .merge_data (merge_data_s)
   );

   // Normalise the incoming request: size 3 is a word; misaligned offsets round down.
   always_comb begin
      if (req_size == 2'd3) begin
         sz_n_s = SZ_WORD;
      end else begin
         sz_n_s = req_size;
      end
      case (sz_n_s)
         SZ_BYTE: begin
            mis_s   = 1'b0;
            off_n_s = req_addr[1:0];
         end
         SZ_HALF: begin
            mis_s   = req_addr[0];
            off_n_s = {req_addr[1], 1'b0};
         end
         default: begin
            mis_s   = (req_addr[1:0] != 2'b00);
            off_n_s = 2'b00;
         end
      endcase
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d     = state_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      mem_addr_d  = mem_addr_q;
      mem_waddr_d = mem_waddr_q;
      mem_wdata_d = mem_wdata_q;
      we_d        = we_q;
      sgn_d       = sgn_q;
      size_d      = size_q;
      off_d       = off_q;
      widx_d      = widx_q;
      wdata_d     = wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               sgn_d   = req_signed;
               size_d  = sz_n_s;
               off_d   = off_n_s;
               widx_d  = req_addr[MEM_AW+1:2];
               wdata_d = req_wdata;
               if (TRAP_EN && mis_s) begin
                  state_d     = ST_RSP;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = 32'h0000_0000;
               end else if (req_we && (sz_n_s == SZ_WORD)) begin
                  state_d     = ST_WR;
                  mem_waddr_d = req_addr[MEM_AW+1:2];
                  mem_wdata_d = req_wdata;
               end else begin
                  state_d    = ST_RD;
                  mem_addr_d = req_addr[MEM_AW+1:2];
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RD: state_d = ST_CAP;
         ST_CAP: begin
            if (we_q) begin
               state_d     = ST_WR;
               mem_waddr_d = widx_q;
               mem_wdata_d = merge_data_s;
            end else begin
               state_d     = ST_RSP;
               rsp_rdata_d = load_data_s;
               rsp_err_d   = 1'b0;
            end
         end
         ST_WR: begin
            state_d     = ST_RSP;
            rsp_rdata_d = 32'h0000_0000;
            rsp_err_d   = 1'b0;
         end
         ST_RSP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RSP;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      req_ready_d = (state_d == ST_IDLE);
      rsp_valid_d = (state_d == ST_RSP);
      mem_we_d    = (state_d == ST_WR);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         rsp_rdata_q <= 32'h0000_0000;
         mem_wdata_q <= 32'h0000_0000;
         wdata_q     <= 32'h0000_0000;
         mem_addr_q  <= '0;
         mem_waddr_q <= '0;
         widx_q      <= '0;
         we_q        <= 1'b0;
         sgn_q       <= 1'b0;
         size_q      <= 2'b00;
         off_q       <= 2'b00;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         mem_we_q    <= mem_we_d;
         rsp_rdata_q <= rsp_rdata_d;
         mem_wdata_q <= mem_wdata_d;
         wdata_q     <= wdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_waddr_q <= mem_waddr_d;
         widx_q      <= widx_d;
         we_q        <= we_d;
         sgn_q       <= sgn_d;
         size_q      <= size_d;
         off_q       <= off_d;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign mem_addr  = mem_addr_q;
   assign mem_waddr = mem_waddr_q;
   assign mem_wdata = mem_wdata_q;
   // A reset landing on the WR cycle must suppress that write.
   assign mem_we    = mem_we_q & ~rst;
endmodule
